// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Width of an index/counter for n items; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Host-side command bus plus SPI pins of the SPI master, with master/slave views.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while busy is low.
// Optional: SPI_LSB_FIRST_EN adds the lsb_first request bit.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 1
);
    localparam int SS_W = spi_pkg::clog2_min1(NUM_SS);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [SS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic              miso;
    logic              mosi;
    logic              sclk;
    logic [NUM_SS-1:0] ss;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              busy;
    logic              err;

`ifdef SPI_LSB_FIRST_EN
    modport master (
        input  start, data_in, cs_sel, cpol, cpha, lsb_first, miso,
        output mosi, sclk, ss, data_out, done, busy, err
    );
    modport slave (
        output start, data_in, cs_sel, cpol, cpha, lsb_first, miso,
        input  mosi, sclk, ss, data_out, done, busy, err
    );
`else
    modport master (
        input  start, data_in, cs_sel, cpol, cpha, miso,
        output mosi, sclk, ss, data_out, done, busy, err
    );
    modport slave (
        output start, data_in, cs_sel, cpol, cpha, miso,
        input  mosi, sclk, ss, data_out, done, busy, err
    );
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, phase/edge strobes and the sclk register.
// Latency: sclk toggles on the clk edge that ends each CLK_DIV-cycle half period in XFER.
// Backpressure: none; counter runs only while run is high and clears otherwise.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic xfer,
    input  logic idle_lvl,
    output logic phase_end,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);
    localparam int CNT_W = clog2_min1(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // A half period ends on the last count; an edge leaving the idle level is a leading edge.
    assign phase_end = run && (cnt_q == CNT_LAST);
    assign lead_stb  = xfer && phase_end && (sclk_q == idle_lvl);
    assign trail_stb = xfer && phase_end && (sclk_q != idle_lvl);
    assign sclk      = sclk_q;

    // Next counter value and sclk level: toggle in XFER, park at the idle level elsewhere.
    always_comb begin
        cnt_d  = '0;
        sclk_d = idle_lvl;
        if (run && !phase_end) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (xfer) begin
            sclk_d = phase_end ? ~sclk_q : sclk_q;
        end
    end

    // Counter and sclk registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, run-time CPOL/CPHA, CLK_DIV divider, NUM_SS selects.
// Latency: done pulses (2*DATA_W+2)*CLK_DIV+1 cycles after the accepted-start cycle.
// Backpressure: start is ignored while busy; out-of-range cs_sel is rejected with an err pulse.
// Optional: SPI_LSB_FIRST_EN adds lsb_first (latched on start) for LSB-first shifting.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 1,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_param_if.master bus
);
    localparam int SS_W = clog2_min1(NUM_SS);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [SS_W:0]   NUM_SS_L = (SS_W + 1)'(NUM_SS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [SS_W-1:0]   cs_q, cs_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic lsb_sel;
    logic lsb_new;
    logic run, xfer, idle_lvl;
    logic phase_end, lead_stb, trail_stb, sclk;
    logic shift_stb, sample_stb;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign lsb_sel = lsb_q;
    assign lsb_new = bus.lsb_first;

    // Bit-order register, latched with the rest of the transfer setup.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else begin
            lsb_q <= lsb_d;
        end
    end
`else
    assign lsb_sel = 1'b0;
    assign lsb_new = 1'b0;
`endif

    function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                   input logic b);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // In IDLE sclk follows the live cpol; during a transfer it uses the latched mode.
    assign run      = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
    assign xfer     = (state_q == XFER);
    assign idle_lvl = (state_q == IDLE) ? bus.cpol : mode_q.cpol;

    // cpha=0 drives on trailing / samples on leading; cpha=1 the other way round.
    assign shift_stb  = mode_q.cpha ? lead_stb : trail_stb;
    assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .xfer      (xfer),
        .idle_lvl  (idle_lvl),
        .phase_end (phase_end),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sclk      (sclk)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cs_d       = cs_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_d     = mosi_q;
        data_out_d = data_out_q;
        err_d      = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if ({1'b0, bus.cs_sel} < NUM_SS_L) begin
                        state_d     = SETUP;
                        mode_d.cpol = bus.cpol;
                        mode_d.cpha = bus.cpha;
                        cs_d        = bus.cs_sel;
                        rx_d        = '0;
                        bit_cnt_d   = '0;
`ifdef SPI_LSB_FIRST_EN
                        lsb_d       = bus.lsb_first;
`endif
                        // cpha=0 needs the first bit on mosi before the first leading edge.
                        if (!bus.cpha) begin
                            mosi_d = out_bit(bus.data_in, lsb_new);
                            tx_d   = shift_out(bus.data_in, lsb_new);
                        end else begin
                            tx_d   = bus.data_in;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (shift_stb) begin
                    mosi_d = out_bit(tx_q, lsb_sel);
                    tx_d   = shift_out(tx_q, lsb_sel);
                end
                if (sample_stb) begin
                    rx_d = shift_in(rx_q, lsb_sel, bus.miso);
                end
                // One bit completes per sclk cycle; the last trailing edge ends the shift phase.
                if (trail_stb) begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d    = DONE;
                    data_out_d = rx_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        if ((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD)) begin
            ss_d = ~(NUM_SS'(1) << cs_d);
        end else begin
            ss_d = '1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            cs_q       <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            mosi_q     <= 1'b0;
            ss_q       <= '1;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cs_q       <= cs_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.mosi     = mosi_q;
    assign bus.sclk     = sclk;
    assign bus.ss       = ss_q;
    assign bus.data_out = data_out_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule
